// File: rtl/ridecore_dmem_pkg.sv
// Shared types and constants for the ridecore data-memory responder.
package ridecore_dmem_pkg;

    localparam int unsigned DmemDataLen = 32;
    localparam int unsigned DmemRamAw   = 12;

    // Response register value out of reset.
    localparam logic [DmemDataLen-1:0] RespRstVal = '0;

    // Pointer width for a write buffer of the given depth.
    function automatic int unsigned wb_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [DmemRamAw-1:0]   addr;
        logic [DmemDataLen-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ridecore_dmem_responder_if.sv
// Core dmem request/response and backing-RAM signals of the responder.
// master: core + RAM side (drives requests and RAM read data); slave: the responder.
interface ridecore_dmem_responder_if
    import ridecore_dmem_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = DmemDataLen,
    parameter int unsigned RAM_AW   = DmemRamAw,
    parameter int unsigned WB_DEPTH = 4
);
    logic [ADDR_LEN-1:0]         dmem_req_addr;
    logic [DATA_LEN-1:0]         dmem_req_data;
    logic                        dmem_req_write_en;
    logic [DATA_LEN-1:0]         dmem_resp_data;
    logic                        ram_en;
    logic                        ram_we;
    logic [RAM_AW-1:0]           ram_addr;
    logic [DATA_LEN-1:0]         ram_wdata;
    logic [DATA_LEN-1:0]         ram_rdata;
    logic [wb_ptr_w(WB_DEPTH):0] wb_count;
    logic                        wb_empty;

    modport master (
        output dmem_req_addr, dmem_req_data, dmem_req_write_en, ram_rdata,
        input  dmem_resp_data, ram_en, ram_we, ram_addr, ram_wdata, wb_count, wb_empty
    );

    modport slave (
        input  dmem_req_addr, dmem_req_data, dmem_req_write_en, ram_rdata,
        output dmem_resp_data, ram_en, ram_we, ram_addr, ram_wdata, wb_count, wb_empty
    );

endinterface

// File: rtl/ridecore_dmem_wbuf.sv
// Store write buffer: circular FIFO with a youngest-match lookup for forwarding.
module ridecore_dmem_wbuf
    import ridecore_dmem_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 4,
    localparam int unsigned WB_PTR_W = wb_ptr_w(WB_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic [DmemRamAw-1:0]   push_addr_i,
    input  logic [DmemDataLen-1:0] push_data_i,
    input  logic                   pop_i,
    input  logic [DmemRamAw-1:0]   lookup_addr_i,
    output logic                   hit_o,
    output logic [DmemDataLen-1:0] hit_data_o,
    output wb_entry_t              head_o,
    output logic [WB_PTR_W:0]      count_o
);
    localparam int unsigned CntW = WB_PTR_W + 1;

    wb_entry_t           entries_q [WB_DEPTH];
    logic [WB_PTR_W-1:0] head_q, tail_q, idx;
    logic [CntW-1:0]     count_q, count_d;

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    // FIFO state; a push into the slot just popped (full buffer) wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (pop_i) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + WB_PTR_W'(1);
            end
            if (push_i) begin
                entries_q[tail_q] <= '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
                tail_q            <= tail_q + WB_PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Walk entries oldest to youngest so the last match found is the youngest.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = head_q;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = head_q + WB_PTR_W'(i);
            if (entries_q[idx].valid && (entries_q[idx].addr == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = entries_q[idx].data;
            end
        end
    end

    assign head_o  = entries_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/ridecore_dmem_responder.sv
// Data-memory responder between the core dmem port and a one-cycle single-port RAM.
// RIDECORE_DMEM_WBUF_EN: when defined, stores go through a write buffer with
// store-to-load forwarding and drain on store cycles; otherwise stores write through.
module ridecore_dmem_responder
    import ridecore_dmem_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = DmemDataLen,
    parameter int unsigned RAM_AW   = DmemRamAw,
    parameter int unsigned WB_DEPTH = 4
) (
    input logic                     clk,
    input logic                     reset_n,
    ridecore_dmem_responder_if.slave bus
);
    localparam int unsigned WB_PTR_W = wb_ptr_w(WB_DEPTH);

    logic [ADDR_LEN-1:0] req_addr;
    logic [RAM_AW-1:0]   req_word;
    logic                is_load;
    logic                unused_addr;
    logic                wb_hit;
    logic [DATA_LEN-1:0] wb_hit_data;

    assign req_addr    = bus.dmem_req_addr;
    assign req_word    = req_addr[RAM_AW+1:2];
    assign unused_addr = ^{req_addr[ADDR_LEN-1:RAM_AW+2], req_addr[1:0]};
    assign is_load     = ~bus.dmem_req_write_en;

`ifdef RIDECORE_DMEM_WBUF_EN
    logic                push, pop;
    wb_entry_t           wb_head;
    logic [WB_PTR_W:0]   wb_cnt;
    logic                unused_head_valid;

    assign unused_head_valid = wb_head.valid;

    ridecore_dmem_wbuf #(
        .WB_DEPTH (WB_DEPTH)
    ) u_wbuf (
        .clk           (clk),
        .reset_n       (reset_n),
        .push_i        (push),
        .push_addr_i   (req_word),
        .push_data_i   (bus.dmem_req_data),
        .pop_i         (pop),
        .lookup_addr_i (req_word),
        .hit_o         (wb_hit),
        .hit_data_o    (wb_hit_data),
        .head_o        (wb_head),
        .count_o       (wb_cnt)
    );

    assign bus.wb_count = wb_cnt;
    assign bus.wb_empty = (wb_cnt == '0);

    // Port arbitration: loads own the RAM; stores push and drain the head if one exists.
    always_comb begin
        push          = 1'b0;
        pop           = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = req_word;
        bus.ram_wdata = bus.dmem_req_data;
        if (is_load) begin
            bus.ram_en = 1'b1;
        end else begin
            push = 1'b1;
            if (wb_cnt != '0) begin
                pop           = 1'b1;
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = wb_head.addr;
                bus.ram_wdata = wb_head.data;
            end
        end
        // Reset kills any in-flight access immediately, not at the next edge.
        if (!reset_n) begin
            push       = 1'b0;
            pop        = 1'b0;
            bus.ram_en = 1'b0;
            bus.ram_we = 1'b0;
        end
    end
`else
    assign wb_hit       = 1'b0;
    assign wb_hit_data  = '0;
    assign bus.wb_count = '0;
    assign bus.wb_empty = 1'b1;

    // Write-through: every request uses the RAM port in its own cycle.
    always_comb begin
        bus.ram_en    = reset_n;
        bus.ram_we    = reset_n & ~is_load;
        bus.ram_addr  = req_word;
        bus.ram_wdata = bus.dmem_req_data;
    end
`endif

    logic                load_q, fwd_hit_q;
    logic [DATA_LEN-1:0] fwd_data_q, hold_q, resp;

    // RAM data arrives after the edge, so the response muxes it in behind the registers.
    assign resp = !load_q    ? hold_q     :
                  fwd_hit_q  ? fwd_data_q : bus.ram_rdata;
    assign bus.dmem_resp_data = resp;

    // Response pipeline: remember load/forward outcome and hold the last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_q     <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= RespRstVal;
            hold_q     <= RespRstVal;
        end else begin
            load_q     <= is_load;
            fwd_hit_q  <= is_load & wb_hit;
            fwd_data_q <= wb_hit_data;
            hold_q     <= resp;
        end
    end

endmodule
